// File: rtl/write_data_if.sv
// Pixel-pair stream in, frame-buffer write port and status out.
// master drives the stream; slave is the write_data sink.
interface write_data_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  vertical_Pulse;
  logic                  horizontal_Pulse;
  logic [7:0]            data_R_Even;
  logic [7:0]            data_G_Even;
  logic [7:0]            data_B_Even;
  logic [7:0]            data_R_Odd;
  logic [7:0]            data_G_Odd;
  logic [7:0]            data_B_Odd;
  logic                  mem_Write_Enable;
  logic [ADDR_WIDTH-1:0] mem_Address;
  logic [47:0]           mem_Data;
  logic [ADDR_WIDTH-1:0] pair_Count;
  logic                  done_Flag;
  logic                  overrun_Flag;

  modport master (
    output vertical_Pulse,
    output horizontal_Pulse,
    output data_R_Even,
    output data_G_Even,
    output data_B_Even,
    output data_R_Odd,
    output data_G_Odd,
    output data_B_Odd,
    input  mem_Write_Enable,
    input  mem_Address,
    input  mem_Data,
    input  pair_Count,
    input  done_Flag,
    input  overrun_Flag
  );

  modport slave (
    input  vertical_Pulse,
    input  horizontal_Pulse,
    input  data_R_Even,
    input  data_G_Even,
    input  data_B_Even,
    input  data_R_Odd,
    input  data_G_Odd,
    input  data_B_Odd,
    output mem_Write_Enable,
    output mem_Address,
    output mem_Data,
    output pair_Count,
    output done_Flag,
    output overrun_Flag
  );
endinterface

// File: rtl/write_data.sv
// Pixel-pair sink: bottom-up frame-buffer addressing,
// one 48-bit BGR pair write per accepted pair.
module write_data #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 18
) (
  input logic         clk,
  input logic         reset,
  write_data_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] HALF =
    ADDR_WIDTH'(IMAGE_WIDTH / 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL =
    ADDR_WIDTH'(IMAGE_WIDTH / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW =
    ADDR_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] TOP_BASE =
    ADDR_WIDTH'((IMAGE_HEIGHT - 1) * (IMAGE_WIDTH / 2));

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic                  vp_q;
  logic                  vp_rise;
  logic                  accept;
  logic                  last_col;
  logic                  last_pair;
  logic [ADDR_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] pair_count;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [47:0]           data;
  logic                  done;
  logic                  overrun;

  assign vp_rise   = bus.vertical_Pulse & ~vp_q;
  assign accept    = (state == CAPTURE)
                   & bus.horizontal_Pulse
                   & ~vp_rise;
  assign last_col  = (col == LAST_COL);
  assign last_pair = last_col & (row == LAST_ROW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sync always wins, including a restart mid-frame.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (vp_rise) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (vp_rise)
          state_next = CAPTURE;
        else if (accept && last_pair)
          state_next = DONE;
      end
      DONE: begin
        if (vp_rise) state_next = CAPTURE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vp_q       <= 1'b0;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      pair_count <= '0;
      we         <= 1'b0;
      addr       <= '0;
      data       <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vp_q <= bus.vertical_Pulse;
      we   <= accept;
      if (bus.horizontal_Pulse && state != CAPTURE)
        overrun <= 1'b1;
      if (vp_rise) begin
        col        <= '0;
        row        <= '0;
        row_base   <= TOP_BASE;
        pair_count <= '0;
        done       <= 1'b0;
        if (state == CAPTURE) overrun <= 1'b1;
      end else if (accept) begin
        addr <= row_base + col;
        data <= {bus.data_B_Odd,
                 bus.data_G_Odd,
                 bus.data_R_Odd,
                 bus.data_B_Even,
                 bus.data_G_Even,
                 bus.data_R_Even};
        pair_count <= pair_count + 1'b1;
        // Row base walks down one buffer row per stream row.
        if (last_col) begin
          col      <= '0;
          row      <= row + 1'b1;
          row_base <= row_base - HALF;
        end else begin
          col <= col + 1'b1;
        end
        if (last_pair) done <= 1'b1;
      end
    end
  end

  assign bus.mem_Write_Enable = we;
  assign bus.mem_Address      = addr;
  assign bus.mem_Data         = data;
  assign bus.pair_Count       = pair_count;
  assign bus.done_Flag        = done;
  assign bus.overrun_Flag     = overrun;

endmodule

// File: tb/tb_write_data.sv
// Randomized bench for write_data against a pair-count
// based reference model, plus directed literal checks.
module tb_write_data;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int AW   = 18;
  localparam int HALF = W / 2;
  localparam int NP   = W * H / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  write_data_if #(.ADDR_WIDTH(AW)) bus ();

  write_data #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               name, act, exp);
    end
  endtask

  // Model: frame progress is just a pair count n.
  bit          m_vp_prev = 0;
  bit          m_cap     = 0;
  bit          m_rise    = 0;
  int          m_n       = 0;
  bit          e_we      = 0;
  bit          e_done    = 0;
  bit          e_ovr     = 0;
  int          e_cnt     = 0;
  logic [AW-1:0] e_addr  = '0;
  logic [47:0]   e_data  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_vp_prev = 0;
      m_cap     = 0;
      m_n       = 0;
      e_we      = 0;
      e_done    = 0;
      e_ovr     = 0;
      e_cnt     = 0;
    end else begin
      m_rise    = bus.vertical_Pulse && !m_vp_prev;
      m_vp_prev = bus.vertical_Pulse;
      e_we      = 0;
      if (bus.horizontal_Pulse && !m_cap) e_ovr = 1;
      if (m_rise) begin
        if (m_cap) e_ovr = 1;
        m_cap  = 1;
        m_n    = 0;
        e_cnt  = 0;
        e_done = 0;
      end else if (bus.horizontal_Pulse && m_cap) begin
        e_we   = 1;
        e_addr = AW'((H - 1 - m_n / HALF) * HALF
                     + m_n % HALF);
        e_data = {bus.data_B_Odd, bus.data_G_Odd,
                  bus.data_R_Odd, bus.data_B_Even,
                  bus.data_G_Even, bus.data_R_Even};
        m_n++;
        e_cnt = m_n;
        if (m_n == NP) begin
          m_cap  = 0;
          e_done = 1;
        end
      end
    end
  end

  logic [AW-1:0] wr_log[$];

  always @(negedge clk) begin
    check("we", bus.mem_Write_Enable, e_we);
    check("done", bus.done_Flag, e_done);
    check("overrun", bus.overrun_Flag, e_ovr);
    check("pair_count", bus.pair_Count, e_cnt);
    if (e_we) begin
      check("addr", bus.mem_Address, e_addr);
      check("data", bus.mem_Data, e_data);
    end
    if (bus.mem_Write_Enable === 1'b1)
      wr_log.push_back(bus.mem_Address);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(logic [47:0] d);
    bus.data_R_Even = d[7:0];
    bus.data_G_Even = d[15:8];
    bus.data_B_Even = d[23:16];
    bus.data_R_Odd  = d[31:24];
    bus.data_G_Odd  = d[39:32];
    bus.data_B_Odd  = d[47:40];
  endtask

  function automatic logic [47:0] rnd_pix();
    return 48'({$urandom, $urandom});
  endfunction

  task automatic vp_pulse();
    bus.vertical_Pulse = 1'b1;
    tick();
    bus.vertical_Pulse = 1'b0;
    tick();
  endtask

  task automatic pair(logic [47:0] d);
    set_pix(d);
    bus.horizontal_Pulse = 1'b1;
    tick();
    bus.horizontal_Pulse = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_frame_addrs(int base, string tag);
    int exp_a[4];
    exp_a = '{2, 3, 0, 1};
    check({tag, "_nwrites"}, wr_log.size() - base, 4);
    if (wr_log.size() - base == 4)
      for (int i = 0; i < 4; i++)
        check({tag, "_addr"}, wr_log[base + i], exp_a[i]);
  endtask

  int base;
  bit vp;
  bit hp;

  initial begin
    bus.vertical_Pulse   = 1'b0;
    bus.horizontal_Pulse = 1'b0;
    set_pix('0);

    @(negedge clk);
    check("rst_we", bus.mem_Write_Enable, 0);
    check("rst_addr", bus.mem_Address, 0);
    check("rst_data", bus.mem_Data, 0);
    check("rst_count", bus.pair_Count, 0);
    check("rst_done", bus.done_Flag, 0);
    check("rst_ovr", bus.overrun_Flag, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Back-to-back frame with a known first pair.
    vp_pulse();
    base = wr_log.size();
    pair(48'h665544332211);
    check("lit_data", bus.mem_Data, 48'h665544332211);
    pair(rnd_pix());
    pair(rnd_pix());
    pair(rnd_pix());
    check("lit_done", bus.done_Flag, 1);
    check("lit_count", bus.pair_Count, 4);
    bus.horizontal_Pulse = 1'b0;
    idle(2);
    check_frame_addrs(base, "frame1");
    check("frame1_ovr", bus.overrun_Flag, 0);

    // Pairs after done are dropped and flagged.
    base = wr_log.size();
    pair(rnd_pix());
    pair(rnd_pix());
    idle(2);
    check("post_done_nw", wr_log.size() - base, 0);
    check("post_done_ovr", bus.overrun_Flag, 1);
    check("post_done_done", bus.done_Flag, 1);

    // Pairs before any frame sync.
    do_reset();
    check("rst2_ovr", bus.overrun_Flag, 0);
    base = wr_log.size();
    pair(rnd_pix());
    pair(rnd_pix());
    idle(2);
    check("pre_vp_nw", wr_log.size() - base, 0);
    check("pre_vp_ovr", bus.overrun_Flag, 1);

    // Abort after three pairs.
    do_reset();
    vp_pulse();
    repeat (3) pair(rnd_pix());
    vp_pulse();
    check("abort_ovr", bus.overrun_Flag, 1);
    check("abort_count", bus.pair_Count, 0);
    base = wr_log.size();
    pair(rnd_pix());
    idle(2);
    check("abort_nw", wr_log.size() - base, 1);
    if (wr_log.size() - base == 1)
      check("abort_addr", wr_log[base], 2);
    repeat (3) pair(rnd_pix());
    idle(2);

    // Pulse toggling every cycle.
    do_reset();
    vp_pulse();
    base = wr_log.size();
    for (int i = 0; i < NP; i++) begin
      pair(rnd_pix());
      tick();
    end
    idle(2);
    check_frame_addrs(base, "toggle");
    check("toggle_done", bus.done_Flag, 1);

    // Reset in the middle of a frame.
    vp_pulse();
    pair(rnd_pix());
    reset = 1'b1;
    #1;
    check("midrst_we", bus.mem_Write_Enable, 0);
    check("midrst_count", bus.pair_Count, 0);
    check("midrst_done", bus.done_Flag, 0);
    tick();
    reset = 1'b0;
    tick();
    base = wr_log.size();
    pair(rnd_pix());
    pair(rnd_pix());
    idle(2);
    check("midrst_nw", wr_log.size() - base, 0);
    vp_pulse();
    base = wr_log.size();
    repeat (NP) pair(rnd_pix());
    idle(2);
    check_frame_addrs(base, "midrst");
    check("midrst_fdone", bus.done_Flag, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      vp = ($urandom_range(0, 99) < 4);
      hp = ($urandom_range(0, 2) != 0);
      if (vp && !m_cap) hp = 0;
      bus.vertical_Pulse   = vp;
      bus.horizontal_Pulse = hp;
      set_pix(rnd_pix());
      tick();
    end
    reset = 1'b0;
    bus.vertical_Pulse   = 1'b0;
    bus.horizontal_Pulse = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
